gf2m_digit_mult: RTL and testbench

- Digit-serial GF(2^163) multiplier, polynomial basis, for the BEC processing core.
- Sits directly downstream of the LA register-load wrapper.
- Consumes two 163-bit operand registers (e.g. rega/regb) once the wrapper enters its processing state.
- Returns the product c = a·b mod f(x), f(x) = x^163 + x^7 + x^6 + x^3 + 1, for the read-out path.

---
 rtl/gf2m_digit_mult.sv | 142 ++++++++++++++
 tb/tb_gf2m_digit_mult.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) multiplier, polynomial basis, MSB-first.
// Computes c = a*b mod f(x), where f(x) = x^M + POLY. The multiplier consumes
// D bits of a per clock. It takes N = ceil(M/D) steps, and then spends one
// cycle in DONE.
module gf2m_digit_mult #(
    parameter int           M    = 163,
    parameter int           D    = 4,
    parameter logic [M-1:0] POLY = {{(M-8){1'b0}}, 8'hC9}
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] c,
    output logic         busy,
    output logic         done
);

    localparam int N  = (M + D - 1) / D;
    localparam int AW = N * D;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [M-1:0]    b_q, b_d;
    logic [M-1:0]    z_q, z_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    c_q, c_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [M-1:0]    step_z_s;

    // One digit step. Each of the D bits does three things in order:
    // multiply Z by x, fold x^M back in through POLY, then add b when the
    // digit bit is set.
    function automatic logic [M-1:0] digit_step(
        input logic [M-1:0] z_in,
        input logic [D-1:0] dig,
        input logic [M-1:0] b_in
    );
        logic [M-1:0] z;
        logic         fb;
        z = z_in;
        for (int j = 0; j < D; j++) begin
            fb = z[M-1];
            z  = {z[M-2:0], 1'b0};
            if (fb) begin
                z = z ^ POLY;
            end
            if (dig[D-1-j]) begin
                z = z ^ b_in;
            end
        end
        return z;
    endfunction

    // The a register shifts left by D each step, so the current digit is
    // always its top D bits.
    assign step_z_s = digit_step(z_q, a_q[AW-1 -: D], b_q);

    // Next-state logic for the FSM and the datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = AW'(a);
                    b_d     = b;
                    z_d     = {M{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                z_d   = step_z_s;
                a_d   = {a_q[AW-D-1:0], {D{1'b0}}};
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    c_d     = step_z_s;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears every register, so no
    // partial result can survive a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= {AW{1'b0}};
            b_q     <= {M{1'b0}};
            z_q     <= {M{1'b0}};
            cnt_q   <= {CW{1'b0}};
            c_q     <= {M{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Testbench for gf2m_digit_mult. It instantiates the multiplier for D = 1, 2,
// 4 and 8, drives all four from shared inputs, and checks each one against
// directed vectors and a right-to-left reference multiplier.
module tb_gf2m_digit_mult;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [162:0] a;
    logic [162:0] b;
    logic [162:0] c_w    [4];
    logic         busy_w [4];
    logic         done_w [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        gf2m_digit_mult #(.M(163), .D(DG)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .start   (start),
            .a       (a),
            .b       (b),
            .c       (c_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g])
        );
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 163;
            1:       return 82;
            2:       return 41;
            default: return 21;
        endcase
    endfunction

    function automatic logic [162:0] xt(input logic [162:0] z);
        logic [162:0] r;
        r = {z[161:0], 1'b0};
        if (z[162]) r = r ^ 163'h0C9;
        return r;
    endfunction

    // Reference multiplier: scans b from LSB to MSB, accumulating a*x^i.
    function automatic logic [162:0] gf_ref(input logic [162:0] x, input logic [162:0] y);
        logic [162:0] acc;
        logic [162:0] aa;
        acc = 163'h0;
        aa  = x;
        for (int i = 0; i < 163; i++) begin
            if (y[i]) acc = acc ^ aa;
            aa = xt(aa);
        end
        return acc;
    endfunction

    task automatic chk(input string nm, input logic [162:0] act, input logic [162:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Starts one multiply on all four instances, then watches them for 200 cycles.
    task automatic run_all(input logic [162:0] ta, input logic [162:0] tb_v,
                           input logic [162:0] expv, input string nm);
        int           lat   [4];
        int           ndone [4];
        logic [162:0] cap   [4];
        logic         prev  [4];
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy_at_start"}, 163'(busy_w[2]), 163'd1);
        for (int d = 0; d < 4; d++) begin
            lat[d] = 0; ndone[d] = 0; cap[d] = 163'h0; prev[d] = 1'b0;
        end
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (prev[d]) begin
                    chk($sformatf("%s d%0d busy_after_done", nm, d), 163'(busy_w[d]), 163'd0);
                    chk($sformatf("%s d%0d done_one_cycle", nm, d), 163'(done_w[d]), 163'd0);
                end
                prev[d] = done_w[d];
                if (done_w[d]) begin
                    ndone[d]++;
                    if (lat[d] == 0) begin
                        lat[d] = cyc;
                        cap[d] = c_w[d];
                        chk($sformatf("%s d%0d busy_at_done", nm, d), 163'(busy_w[d]), 163'd1);
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s d%0d latency", nm, d), 163'(lat[d]), 163'(lat_of(d)));
            chk($sformatf("%s d%0d done_count", nm, d), 163'(ndone[d]), 163'd1);
            chk($sformatf("%s d%0d product", nm, d), cap[d], expv);
            chk($sformatf("%s d%0d held", nm, d), c_w[d], expv);
        end
    endtask

    typedef struct {
        logic [162:0] va;
        logic [162:0] vb;
        logic [162:0] ve;
    } vec_t;

    vec_t         vt [8];
    logic [162:0] one;
    logic [162:0] top;
    logic [162:0] ones;
    logic [191:0] wa;
    logic [191:0] wb;
    logic [162:0] p1;
    logic [162:0] p2;
    int           nd;

    initial begin
        one  = 163'h1;
        top  = one << 162;
        ones = {163{1'b1}};
        vt[0] = '{one,  163'h2, 163'h2};
        vt[1] = '{top,  163'h2, 163'h0C9};
        vt[2] = '{top,  top,    gf_ref(top, top)};
        vt[3] = '{163'h0, ones, 163'h0};
        vt[4] = '{one,  ones,   ones};
        vt[5] = '{ones, one,    ones};
        vt[6] = '{top,  163'h4, 163'h192};
        vt[7] = '{ones, 163'h0, 163'h0};

        reset_n = 1'b0; start = 1'b0; a = 163'h0; b = 163'h0;
        #12;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset d%0d c", d), c_w[d], 163'h0);
            chk($sformatf("reset d%0d busy", d), 163'(busy_w[d]), 163'd0);
            chk($sformatf("reset d%0d done", d), 163'(done_w[d]), 163'd0);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset busy", 163'(busy_w[2]), 163'd0);

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_all(vt[i].va, vt[i].vb, vt[i].ve, $sformatf("vec%0d", i));
        end

        // Start while busy: a second start arrives mid-run and is held high through DONE.
        p1 = gf_ref(163'h1234_5678_9ABC, ones);
        p2 = gf_ref(top | 163'h7, 163'h3);
        nd = 0;
        @(negedge clk);
        a = 163'h1234_5678_9ABC; b = ones; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 10) begin
                a = top | 163'h7; b = 163'h3; start = 1'b1;
            end
            if (done_w[2]) begin
                nd++;
                if (nd == 1) begin
                    chk("swb first_done_cycle", 163'(cyc), 163'd41);
                    chk("swb first_product", c_w[2], p1);
                end else begin
                    chk("swb second_done_cycle", 163'(cyc), 163'd84);
                    chk("swb second_product", c_w[2], p2);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("swb done_count", 163'(nd), 163'd2);
        repeat (200) @(posedge clk);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = ones; b = ones; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("midrst d%0d c", d), c_w[d], 163'h0);
            chk($sformatf("midrst d%0d busy", d), 163'(busy_w[d]), 163'd0);
            chk($sformatf("midrst d%0d done", d), 163'(done_w[d]), 163'd0);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            if (done_w[2] || busy_w[2]) nd++;
        end
        chk("midrst no_activity", 163'(nd), 163'd0);
        run_all(top | 163'h55, 163'hABCDEF, gf_ref(top | 163'h55, 163'hABCDEF), "midrst_restart");

        // Random operands.
        for (int r = 0; r < 20; r++) begin
            wa = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            wb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            run_all(wa[162:0], wb[162:0], gf_ref(wa[162:0], wb[162:0]), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
